// File: rtl/net_if_pkg.sv
// rtl/net_if_pkg.sv - shared network word width and default FIFO depths for core and router
package net_if_pkg;

   localparam int NET_DATA_W   = 32;
   localparam int NET_TX_DEPTH = 4;
   localparam int NET_RX_DEPTH = 4;

   // Occupancy counters need one extra bit so a full FIFO (count == DEPTH) is representable.
   function automatic int count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/core_net_interface_if.sv
// rtl/core_net_interface_if.sv - core MEM-stage and router-port signals of the network endpoint
interface core_net_interface_if
   import net_if_pkg::*;
#(
   parameter int DATA_W   = NET_DATA_W,
   parameter int TX_DEPTH = NET_TX_DEPTH,
   parameter int RX_DEPTH = NET_RX_DEPTH
) ();

   logic                        NET_WRITE;
   logic [DATA_W-1:0]           NET_WRITE_DATA;
   logic                        NET_READ;
   logic [DATA_W-1:0]           NET_READ_DATA;
   logic                        NET_STALL;
   logic                        TX_VALID;
   logic [DATA_W-1:0]           TX_DATA;
   logic                        TX_READY;
   logic                        RX_VALID;
   logic [DATA_W-1:0]           RX_DATA;
   logic                        RX_READY;
   logic [$clog2(TX_DEPTH):0]   TX_COUNT;
   logic [$clog2(RX_DEPTH):0]   RX_COUNT;

   // The endpoint itself is the slave; the core pipeline and router together act as master.
   modport slave (
      input  NET_WRITE, NET_WRITE_DATA, NET_READ, TX_READY, RX_VALID, RX_DATA,
      output NET_READ_DATA, NET_STALL, TX_VALID, TX_DATA, RX_READY, TX_COUNT, RX_COUNT
   );

   modport master (
      output NET_WRITE, NET_WRITE_DATA, NET_READ, TX_READY, RX_VALID, RX_DATA,
      input  NET_READ_DATA, NET_STALL, TX_VALID, TX_DATA, RX_READY, TX_COUNT, RX_COUNT
   );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] din_i,
   output logic [DATA_W-1:0] dout_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CW-1:0]     count_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // Full/empty come from registered state only, so a push into a full FIFO is refused
   // even when a pop frees a slot on the same edge.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/core_net_interface.sv
// rtl/core_net_interface.sv - core-side NoC endpoint: TX/RX FIFOs plus handshake and stall glue
module core_net_interface
   import net_if_pkg::*;
#(
   parameter int DATA_W   = NET_DATA_W,
   parameter int TX_DEPTH = NET_TX_DEPTH,
   parameter int RX_DEPTH = NET_RX_DEPTH
) (
   input  logic                 CLK,
   input  logic                 RESET,
   core_net_interface_if.slave  net
);

   logic tx_full, tx_empty, rx_full, rx_empty;
   logic tx_push, tx_pop, rx_push, rx_pop;

   // Requests arriving while RESET is high are dropped rather than stalled.
   assign tx_push = !RESET && net.NET_WRITE && !tx_full;
   assign tx_pop  = !RESET && !tx_empty && net.TX_READY;
   assign rx_push = !RESET && net.RX_VALID && !rx_full;
   assign rx_pop  = !RESET && net.NET_READ && !rx_empty;

   assign net.TX_VALID  = !RESET && !tx_empty;
   assign net.RX_READY  = !RESET && !rx_full;
   assign net.NET_STALL = !RESET && ((net.NET_WRITE && tx_full) || (net.NET_READ && rx_empty));

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .push_i  (tx_push),
      .pop_i   (tx_pop),
      .din_i   (net.NET_WRITE_DATA),
      .dout_o  (net.TX_DATA),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .count_o (net.TX_COUNT)
   );

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .push_i  (rx_push),
      .pop_i   (rx_pop),
      .din_i   (net.RX_DATA),
      .dout_o  (net.NET_READ_DATA),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .count_o (net.RX_COUNT)
   );

endmodule

// File: tb/tb_core_net_interface.sv
// tb/tb_core_net_interface.sv - directed and randomized checks of core_net_interface against a queue model
module tb_core_net_interface;
   import net_if_pkg::*;

   localparam int DW = NET_DATA_W;
   localparam int TD = NET_TX_DEPTH;
   localparam int RD = NET_RX_DEPTH;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   core_net_interface_if #(.DATA_W(DW), .TX_DEPTH(TD), .RX_DEPTH(RD)) nif ();

   core_net_interface #(.DATA_W(DW), .TX_DEPTH(TD), .RX_DEPTH(RD)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .net   (nif.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] tx_m[$];
   logic [DW-1:0] rx_m[$];
   bit last_stall = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      nif.NET_WRITE = 1'b0; nif.NET_WRITE_DATA = '0; nif.NET_READ = 1'b0;
      nif.TX_READY = 1'b0; nif.RX_VALID = 1'b0; nif.RX_DATA = '0;
   endtask

   // One clock cycle: check outputs against the model, advance the model, cross the edge.
   task automatic step();
      bit tx_full, rx_empty, exp_stall, do_txw, do_txr, do_rxw, do_rxr;
      #1;
      tx_full   = (tx_m.size() == TD);
      rx_empty  = (rx_m.size() == 0);
      exp_stall = !RESET && ((nif.NET_WRITE && tx_full) || (nif.NET_READ && rx_empty));
      check("tx_valid", 32'(nif.TX_VALID), 32'(!RESET && tx_m.size() > 0));
      check("tx_data",  32'(nif.TX_DATA),  (tx_m.size() > 0) ? 32'(tx_m[0]) : 32'd0);
      check("rx_ready", 32'(nif.RX_READY), 32'(!RESET && rx_m.size() < RD));
      check("rd_data",  32'(nif.NET_READ_DATA), rx_empty ? 32'd0 : 32'(rx_m[0]));
      check("stall",    32'(nif.NET_STALL), 32'(exp_stall));
      check("tx_count", 32'(nif.TX_COUNT), 32'(tx_m.size()));
      check("rx_count", 32'(nif.RX_COUNT), 32'(rx_m.size()));
      last_stall = exp_stall;
      if (RESET) begin
         tx_m.delete();
         rx_m.delete();
      end else begin
         do_txw = nif.NET_WRITE && !tx_full;
         do_txr = (tx_m.size() > 0) && nif.TX_READY;
         do_rxw = nif.RX_VALID && (rx_m.size() < RD);
         do_rxr = nif.NET_READ && !rx_empty;
         if (do_txr) void'(tx_m.pop_front());
         if (do_txw) tx_m.push_back(nif.NET_WRITE_DATA);
         if (do_rxr) void'(rx_m.pop_front());
         if (do_rxw) rx_m.push_back(nif.RX_DATA);
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      logic [DW-1:0] exp_b [4];
      exp_b[0] = 32'hB2; exp_b[1] = 32'hB3; exp_b[2] = 32'hB4; exp_b[3] = 32'hB5;
      idle();
      RESET = 1'b1;
      nif.RX_VALID = 1'b1;
      nif.RX_DATA  = 32'hDEAD;
      @(posedge CLK);
      @(negedge CLK);
      step();
      RESET = 1'b0;
      idle();
      step();

      // TX ordering
      for (int i = 0; i < 3; i++) begin
         nif.NET_WRITE = 1'b1; nif.NET_WRITE_DATA = 32'hA1 + i;
         step();
      end
      nif.NET_WRITE = 1'b0;
      #1 check("t2_count", 32'(nif.TX_COUNT), 32'd3);
      nif.TX_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("t2_data", 32'(nif.TX_DATA), 32'hA1 + i);
         step();
      end
      idle();

      // TX full stall; a same-cycle drain does not release it
      for (int i = 0; i < 4; i++) begin
         nif.NET_WRITE = 1'b1; nif.NET_WRITE_DATA = 32'hB1 + i;
         step();
      end
      nif.NET_WRITE_DATA = 32'hB5;
      #1 check("t3_stall_full", 32'(nif.NET_STALL), 32'd1);
      step();
      nif.TX_READY = 1'b1;
      #1 check("t3_stall_drain", 32'(nif.NET_STALL), 32'd1);
      step();
      nif.TX_READY = 1'b0;
      #1 check("t3_stall_clear", 32'(nif.NET_STALL), 32'd0);
      step();
      idle();
      nif.TX_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 check("t3_order", 32'(nif.TX_DATA), 32'(exp_b[i]));
         step();
      end
      idle();

      // RX empty stall; same-cycle arrival does not satisfy the read
      nif.NET_READ = 1'b1;
      #1 check("t4_stall_empty", 32'(nif.NET_STALL), 32'd1);
      step();
      nif.RX_VALID = 1'b1; nif.RX_DATA = 32'h55;
      #1 check("t4_stall_arrive", 32'(nif.NET_STALL), 32'd1);
      step();
      nif.RX_VALID = 1'b0;
      #1 check("t4_rd_data", 32'(nif.NET_READ_DATA), 32'h55);
      check("t4_stall_clear", 32'(nif.NET_STALL), 32'd0);
      step();
      idle();
      #1 check("t4_rx_count", 32'(nif.RX_COUNT), 32'd0);
      step();

      // RX full backpressure
      nif.RX_VALID = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nif.RX_DATA = 32'h10 + i;
         step();
      end
      nif.RX_DATA = 32'h14;
      #1 check("t5_rx_ready", 32'(nif.RX_READY), 32'd0);
      step();
      nif.NET_READ = 1'b1;
      #1 check("t5_pop_head", 32'(nif.NET_READ_DATA), 32'h10);
      step();
      nif.NET_READ = 1'b0;
      #1 check("t5_ready_again", 32'(nif.RX_READY), 32'd1);
      step();
      nif.RX_VALID = 1'b0;
      nif.NET_READ = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 check("t5_order", 32'(nif.NET_READ_DATA), 32'h11 + i);
         step();
      end
      idle();

      // Reset mid-flight
      for (int i = 0; i < 3; i++) begin
         nif.NET_WRITE = (i < 2); nif.NET_WRITE_DATA = 32'hC0 + i;
         nif.RX_VALID = 1'b1; nif.RX_DATA = 32'hD0 + i;
         step();
      end
      idle();
      #1 check("t6_tx_pre", 32'(nif.TX_COUNT), 32'd2);
      check("t6_rx_pre", 32'(nif.RX_COUNT), 32'd3);
      RESET = 1'b1;
      nif.NET_READ = 1'b1;
      nif.NET_WRITE = 1'b1;
      step();
      RESET = 1'b0;
      nif.NET_WRITE = 1'b0;
      #1 check("t6_tx_count", 32'(nif.TX_COUNT), 32'd0);
      check("t6_tx_valid", 32'(nif.TX_VALID), 32'd0);
      check("t6_read_stall", 32'(nif.NET_STALL), 32'd1);
      step();
      idle();

      // Randomized traffic; core holds its request and data while stalled
      for (int c = 0; c < 600; c++) begin
         if (!last_stall) begin
            nif.NET_WRITE      = ($urandom_range(0, 99) < 45);
            nif.NET_WRITE_DATA = $urandom;
            nif.NET_READ       = ($urandom_range(0, 99) < 40);
         end
         nif.TX_READY = ($urandom_range(0, 99) < 50);
         nif.RX_VALID = ($urandom_range(0, 99) < 50);
         nif.RX_DATA  = $urandom;
         RESET        = ($urandom_range(0, 99) == 0);
         step();
      end
      RESET = 1'b0;
      idle();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
